eth_rmii_tx: RTL and testbench

//  RMII (100 Mb/s) Ethernet transmitter: the transmit counterpart of eth_rmii_rx on the same PHY.

---
 rtl/eth_rmii_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_eth_rmii_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_rmii_tx.sv
// RMII 100 Mb/s Ethernet transmitter: adds preamble/SFD, pads short frames to minimum
// length, appends CRC-32 FCS and enforces the inter-frame gap before the next frame.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line quiet, waiting for valid to start a frame
// S_PRE   | sending 0x55 preamble bytes (tmr_q counts remaining bytes)
// S_SFD   | sending 0xD5; requests the first data byte on its last dibit
// S_DATA  | sending client bytes; requests the next one on dibit 3
// S_PAD   | sending 0x00 until the data+pad count reaches MIN_FRAME
// S_FCS   | sending ~CRC, 16 dibits, LSB first (tmr_q counts bytes)
// S_IFG   | txen low for IFG_BYTES*4 clocks (tmr_q counts clocks)
module eth_rmii_tx #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_FRAME      = 60,
  parameter int IFG_BYTES      = 12
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  input  logic       eop,
  output logic       ready,
  output logic [1:0] tx,
  output logic       txen,
  output logic       busy,
  output logic       underrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_PAD  = 3'd4;
  localparam logic [2:0] S_FCS  = 3'd5;
  localparam logic [2:0] S_IFG  = 3'd6;

  localparam int              TMR_W    = 8;
  localparam logic [TMR_W-1:0] PRE_LOAD = TMR_W'(PREAMBLE_BYTES - 1);
  localparam logic [TMR_W-1:0] FCS_LOAD = TMR_W'(3);
  localparam logic [TMR_W-1:0] IFG_LOAD = TMR_W'(IFG_BYTES * 4 - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [10:0]      MIN_CNT  = 11'(MIN_FRAME);
  localparam logic [10:0]      CNT_MAX  = 11'h7FF;
  localparam logic [31:0]      CRC_POLY = 32'hEDB88320;

  logic [2:0]       state_q, state_d;
  logic [1:0]       dibit_q, dibit_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [31:0]      sh_q, sh_d;
  logic             eop_q, eop_d;
  logic [10:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]      crc_q, crc_d;
  logic [1:0]       tx_q, tx_d;
  logic             txen_q, txen_d;
  logic             underrun_q, underrun_d;

  logic             ready_c;
  logic             take_byte;
  logic             end_of_data;
  logic             goto_ifg;
  logic [31:0]      crc_upd;
  logic [31:0]      fcs_val;
  logic [10:0]      cnt_inc;

  // Reflected CRC-32, two bits per clock in wire order (tx[0] first).
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    dibit_d     = dibit_q + 2'd1;
    tmr_d       = tmr_q;
    sh_d        = sh_q >> 2;
    tx_d        = sh_q[1:0];
    eop_d       = eop_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    txen_d      = txen_q;
    underrun_d  = 1'b0;
    ready_c     = 1'b0;
    take_byte   = 1'b0;
    end_of_data = 1'b0;
    goto_ifg    = 1'b0;
    crc_upd     = crc_dibit(crc_q, tx_q);
    fcs_val     = ~crc_upd;
    cnt_inc     = (byte_cnt_q == CNT_MAX) ? byte_cnt_q : byte_cnt_q + 11'd1;

    case (state_q)
      S_IDLE: begin
        dibit_d = 2'd0;
        tx_d    = 2'b00;
        sh_d    = '0;
        txen_d  = 1'b0;
        if (valid) begin
          state_d    = S_PRE;
          tmr_d      = PRE_LOAD;
          tx_d       = 2'b01;
          sh_d       = {24'd0, 8'h55} >> 2;
          txen_d     = 1'b1;
          eop_d      = 1'b0;
          byte_cnt_d = '0;
        end
      end
      S_PRE: begin
        if (dibit_q == 2'd3) begin
          tx_d = 2'b01;
          if (tmr_q == '0) begin
            state_d = S_SFD;
            sh_d    = {24'd0, 8'hD5} >> 2;
          end else begin
            tmr_d = tmr_q - TMR_ONE;
            sh_d  = {24'd0, 8'h55} >> 2;
          end
        end
      end
      S_SFD: begin
        crc_d = '1;
        if (dibit_q == 2'd3) begin
          ready_c   = 1'b1;
          take_byte = 1'b1;
        end
      end
      S_DATA: begin
        crc_d = crc_upd;
        if (dibit_q == 2'd3) begin
          if (eop_q) begin
            end_of_data = 1'b1;
          end else begin
            ready_c   = 1'b1;
            take_byte = 1'b1;
          end
        end
      end
      S_PAD: begin
        crc_d = crc_upd;
        if (dibit_q == 2'd3) end_of_data = 1'b1;
      end
      S_FCS: begin
        if (dibit_q == 2'd3) begin
          if (tmr_q == '0) goto_ifg = 1'b1;
          else             tmr_d    = tmr_q - TMR_ONE;
        end
      end
      S_IFG: begin
        dibit_d = 2'd0;
        tx_d    = 2'b00;
        sh_d    = '0;
        txen_d  = 1'b0;
        if (tmr_q == '0) state_d = S_IDLE;
        else             tmr_d   = tmr_q - TMR_ONE;
      end
      default: begin
        state_d = S_IDLE;
        txen_d  = 1'b0;
        tx_d    = 2'b00;
      end
    endcase

    // A request with nothing offered aborts the frame; the far end sees a bad FCS.
    if (take_byte) begin
      if (valid) begin
        state_d    = S_DATA;
        tx_d       = data[1:0];
        sh_d       = {24'd0, data} >> 2;
        eop_d      = eop;
        byte_cnt_d = cnt_inc;
      end else begin
        underrun_d = 1'b1;
        goto_ifg   = 1'b1;
      end
    end

    if (end_of_data) begin
      if (byte_cnt_q < MIN_CNT) begin
        state_d    = S_PAD;
        tx_d       = 2'b00;
        sh_d       = '0;
        byte_cnt_d = cnt_inc;
      end else begin
        state_d = S_FCS;
        tmr_d   = FCS_LOAD;
        tx_d    = fcs_val[1:0];
        sh_d    = fcs_val >> 2;
      end
    end

    if (goto_ifg) begin
      state_d = S_IFG;
      tmr_d   = IFG_LOAD;
      tx_d    = 2'b00;
      sh_d    = '0;
      txen_d  = 1'b0;
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dibit_q    <= 2'd0;
      tmr_q      <= '0;
      sh_q       <= '0;
      eop_q      <= 1'b0;
      byte_cnt_q <= '0;
      crc_q      <= '1;
      tx_q       <= 2'b00;
      txen_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dibit_q    <= dibit_d;
      tmr_q      <= tmr_d;
      sh_q       <= sh_d;
      eop_q      <= eop_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      tx_q       <= tx_d;
      txen_q     <= txen_d;
      underrun_q <= underrun_d;
    end
  end

  assign ready    = ready_c;
  assign tx       = tx_q;
  assign txen     = txen_q;
  assign busy     = (state_q != S_IDLE);
  assign underrun = underrun_q;

endmodule

// File: tb/tb_eth_rmii_tx.sv
// Bench for eth_rmii_tx: random frames driven over valid/ready, wire dibits compared against
// a byte-level frame model (preamble, SFD, data, pad, CRC-32 FCS) plus timing checks.
module tb_eth_rmii_tx;

  typedef logic [7:0] bq_t [$];
  typedef logic [1:0] dq_t [$];

  logic       clk50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data  = 8'd0;
  logic       valid = 1'b0;
  logic       eop   = 1'b0;
  logic       ready;
  logic [1:0] tx;
  logic       txen;
  logic       busy;
  logic       underrun;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int prev_fall = 0;

  eth_rmii_tx dut (
    .clk50(clk50), .reset(reset), .data(data), .valid(valid), .eop(eop),
    .ready(ready), .tx(tx), .txen(txen), .busy(busy), .underrun(underrun)
  );

  always #10 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] crc_raw(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'd0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Expected wire dibits: whole frame, or only up to the dropped byte.
  function automatic dq_t expect_wire(input bq_t d, input int drop_at);
    bq_t f, body;
    dq_t w;
    logic [31:0] fcs;
    for (int i = 0; i < 7; i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    if (drop_at >= 0) begin
      for (int i = 0; i < drop_at; i++) f.push_back(d[i]);
    end else begin
      body = d;
      while (body.size() < 60) body.push_back(8'h00);
      fcs = ~crc_raw(body);
      foreach (body[i]) f.push_back(body[i]);
      for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
    end
    foreach (f[i]) for (int j = 0; j < 4; j++) w.push_back(f[i][2*j +: 2]);
    return w;
  endfunction

  function automatic bq_t rand_frame(input int len);
    bq_t d;
    for (int i = 0; i < len; i++) d.push_back(8'($urandom_range(0, 255)));
    return d;
  endfunction

  task automatic run_frame(input bq_t d, input int drop_at, input int rst_at,
                           input bit wait_idle, input bit chk_gap, input bit keep_valid);
    dq_t got, exp;
    bq_t rx;
    int  rise, fall, first_rdy, und, und_fall, nb, nbad, guard;
    rise = 0; fall = 0; first_rdy = -1; und = 0; und_fall = 0; nb = 0;
    if (wait_idle) begin
      guard = 0;
      @(negedge clk50);
      while (busy && guard < 2000) begin @(negedge clk50); guard++; end
      if (busy) chk_eq("idle_timeout", 1, 0);
    end
    valid = 1'b1;
    data  = d[0];
    eop   = (d.size() == 1);
    fork
      begin : drv
        int  idx;
        int  g;
        bit  stop;
        bit  acc;
        idx = 0; g = 0; stop = 0;
        while (!stop) begin
          if (g++ > 5000) begin
            chk_eq("drv_timeout", 1, 0);
            valid = 1'b0;
            stop  = 1;
          end else if (rst_at >= 0 && idx == rst_at) begin
            reset = 1'b1; valid = 1'b0; eop = 1'b0;
            @(posedge clk50); #1;
            chk_eq("rst_txen", txen, 0);
            chk_eq("rst_ready", ready, 0);
            chk_eq("rst_busy", busy, 0);
            reset = 1'b0;
            stop  = 1;
          end else if (ready && idx == drop_at) begin
            valid = 1'b0; eop = 1'b0;
            stop  = 1;
          end else begin
            acc = ready;
            @(negedge clk50);
            if (acc) begin
              idx++;
              if (idx == d.size()) begin
                stop = 1; eop = 1'b0;
                if (keep_valid) data = 8'h00;
                else valid = 1'b0;
              end else begin
                data = d[idx];
                eop  = (idx == d.size() - 1);
              end
            end
          end
        end
      end
      begin : mon
        int t;
        t = 0;
        while (!txen && t < 600) begin @(negedge clk50); t++; end
        if (!txen) begin
          chk_eq("txen_rise", 0, 1);
        end else begin
          rise = cyc;
          if (chk_gap) chk_eq("ifg_gap_ge48", (rise - prev_fall) >= 48, 1);
          while (txen && t < 6000) begin
            got.push_back(tx);
            if (ready && first_rdy < 0) first_rdy = cyc - rise;
            @(negedge clk50); t++;
            und += int'(underrun);
          end
          fall = cyc;
          und_fall = int'(underrun);
          while (busy && nb < 200) begin nb++; @(negedge clk50); und += int'(underrun); end
        end
      end
    join
    if (rst_at < 0) begin
      exp = expect_wire(d, drop_at);
      chk_eq("txen_len", got.size(), exp.size());
      nbad = 0;
      for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] !== exp[i]) nbad++;
      chk_eq("dibits_bad", nbad, 0);
      chk_eq("first_ready", first_rdy, 31);
      chk_eq("underrun_n", und, (drop_at >= 0) ? 1 : 0);
      chk_eq("und_at_fall", und_fall, (drop_at >= 0) ? 1 : 0);
      chk_eq("ifg_busy", nb, 48);
      if (drop_at < 0) begin
        for (int i = 32; i + 3 < got.size(); i += 4) rx.push_back({got[i+3], got[i+2], got[i+1], got[i]});
        chk_eq("fcs_residue", crc_raw(rx), 32'hDEBB20E3);
      end
    end
    prev_fall = fall;
  endtask

  initial begin
    bq_t d;
    reset = 1'b1;
    repeat (3) @(posedge clk50);
    @(negedge clk50);
    chk_eq("rst_tx", tx, 0);
    chk_eq("rst_txen0", txen, 0);
    chk_eq("rst_ready0", ready, 0);
    chk_eq("rst_busy0", busy, 0);
    chk_eq("rst_underrun", underrun, 0);
    reset = 1'b0;

    d = {};
    for (int i = 0; i < 60; i++) d.push_back(8'(i));
    run_frame(d, -1, -1, 1, 0, 0);

    run_frame(rand_frame(10), -1, -1, 1, 0, 0);

    run_frame(rand_frame(100), -1, -1, 1, 0, 1);
    run_frame(rand_frame(40), -1, -1, 0, 1, 0);

    run_frame(rand_frame(80), 20, -1, 1, 0, 0);
    run_frame(rand_frame(70), -1, -1, 1, 0, 0);

    run_frame(rand_frame(80), -1, 30, 1, 0, 0);
    run_frame(rand_frame(64), -1, -1, 1, 0, 0);

    run_frame(rand_frame(59), -1, -1, 1, 0, 0);
    run_frame(rand_frame(61), -1, -1, 1, 0, 0);
    run_frame(rand_frame(1), -1, -1, 1, 0, 0);
    for (int n = 0; n < 4; n++) run_frame(rand_frame($urandom_range(1, 130)), -1, -1, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
